sram_bit_column_path: RTL and testbench



---
 rtl/sram_pkg.sv | 27 ++
 rtl/sram_bit_column_path_if.sv | 26 ++
 rtl/sram_col_slice.sv | 90 +++++++++
 rtl/sram_bit_column_path.sv | 43 ++++
 tb/tb_sram_bit_column_path.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and pad-level thresholds for the SRAM bit-column datapath.
package sram_pkg;

    typedef enum logic [1:0] {
        DATA_TRUE  = 2'd0,
        DATA_FALSE = 2'd1,
        INDET      = 2'd2
    } state_data;

    localparam int TRUE_MIN_MV  = 1300;
    localparam int TRUE_MAX_MV  = 2200;
    localparam int FALSE_MIN_MV = -500;
    localparam int FALSE_MAX_MV = 700;

    // Limits are exclusive; FALSE_MIN_MV cannot bind for unsigned codes but is kept for the analog model.
    function automatic state_data classify_mv(input int mv);
        state_data st;
        st = INDET;
        if ((mv > TRUE_MIN_MV) && (mv < TRUE_MAX_MV)) begin
            st = DATA_TRUE;
        end else if ((mv > FALSE_MIN_MV) && (mv < FALSE_MAX_MV)) begin
            st = DATA_FALSE;
        end
        return st;
    endfunction

endpackage

// File: rtl/sram_bit_column_path_if.sv
// Row bus of the bit-column path: write/read wordlines, data and per-column analog codes.
interface sram_bit_column_path_if #(
    parameter int COLS = 1,
    parameter int MV_W = 12
);
    logic [COLS-1:0]      data_in;
    logic                 row_wr;
    logic                 row_rd;
    logic [COLS-1:0]      bl_wr;
    logic [COLS-1:0]      blb_wr;
    logic [COLS*MV_W-1:0] bl_rd_mv;
    logic [COLS*MV_W-1:0] blb_rd_mv;
    logic [COLS*MV_W-1:0] preout_mv;
    logic [COLS*2-1:0]    data_state;
    logic [COLS-1:0]      dout;

    modport master (
        output data_in, row_wr, row_rd,
        input  bl_wr, blb_wr, bl_rd_mv, blb_rd_mv, preout_mv, data_state, dout
    );

    modport slave (
        input  data_in, row_wr, row_rd,
        output bl_wr, blb_wr, bl_rd_mv, blb_rd_mv, preout_mv, data_state, dout
    );
endinterface

// File: rtl/sram_col_slice.sv
// One column: write driver, 2-port bitcell, registered sense amp and level classifier.
// Optional macro SRAM_RD_PRECHARGE_EN precharges the read bitlines on idle cycles.
module sram_col_slice
    import sram_pkg::*;
#(
    parameter int MV_W            = 12,
    parameter int VDD_MV          = 1500,
    parameter int SENSE_MARGIN_MV = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            data_in_i,
    input  logic            row_wr_i,
    input  logic            row_rd_i,
    output logic            bl_wr_o,
    output logic            blb_wr_o,
    output logic [MV_W-1:0] bl_rd_mv_o,
    output logic [MV_W-1:0] blb_rd_mv_o,
    output logic [MV_W-1:0] preout_mv_o,
    output state_data       data_state_o,
    output logic            dout_o
);

    localparam logic [MV_W-1:0]   VDD_CODE  = MV_W'(VDD_MV);
    localparam logic [MV_W-1:0]   HALF_CODE = MV_W'(VDD_MV / 2);
    localparam logic signed [MV_W:0] MARGIN = (MV_W+1)'(SENSE_MARGIN_MV);

    logic              q_q, q_d;
    logic [MV_W-1:0]   bl_rd_q, bl_rd_d;
    logic [MV_W-1:0]   blb_rd_q, blb_rd_d;
    logic [MV_W-1:0]   pre_q, pre_d;
    logic signed [MV_W:0] diff;

    assign bl_wr_o  = data_in_i;
    assign blb_wr_o = ~data_in_i;

    // Reads use the current q, so a simultaneous write is seen only by the next read.
    always_comb begin
        q_d      = q_q;
        bl_rd_d  = bl_rd_q;
        blb_rd_d = blb_rd_q;
        pre_d    = pre_q;
        diff     = $signed({1'b0, bl_rd_q}) - $signed({1'b0, blb_rd_q});

        if (row_wr_i && (bl_wr_o != blb_wr_o)) begin
            q_d = bl_wr_o;
        end

        if (row_rd_i) begin
            bl_rd_d  = q_q ? VDD_CODE : '0;
            blb_rd_d = q_q ? '0 : VDD_CODE;
        end else begin
`ifdef SRAM_RD_PRECHARGE_EN
            bl_rd_d  = VDD_CODE;
            blb_rd_d = VDD_CODE;
`else
            bl_rd_d  = bl_rd_q;
            blb_rd_d = blb_rd_q;
`endif
        end

        // Equal or weakly split bitlines leave the latched level untouched.
        if (diff > MARGIN) begin
            pre_d = VDD_CODE;
        end else if (diff < -MARGIN) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= 1'b0;
            bl_rd_q  <= VDD_CODE;
            blb_rd_q <= VDD_CODE;
            pre_q    <= HALF_CODE;
        end else begin
            q_q      <= q_d;
            bl_rd_q  <= bl_rd_d;
            blb_rd_q <= blb_rd_d;
            pre_q    <= pre_d;
        end
    end

    assign bl_rd_mv_o   = bl_rd_q;
    assign blb_rd_mv_o  = blb_rd_q;
    assign preout_mv_o  = pre_q;
    assign data_state_o = classify_mv(int'(pre_q));
    assign dout_o       = (data_state_o == DATA_TRUE);

endmodule

// File: rtl/sram_bit_column_path.sv
// Per-row SRAM datapath: COLS column slices sharing the write and read wordlines.
// Optional macro SRAM_RD_PRECHARGE_EN is handled inside sram_col_slice.
module sram_bit_column_path
    import sram_pkg::*;
#(
    parameter int COLS            = 1,
    parameter int MV_W            = 12,
    parameter int VDD_MV          = 1500,
    parameter int SENSE_MARGIN_MV = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_bit_column_path_if.slave  bus
);

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            state_data col_state;

            sram_col_slice #(
                .MV_W            (MV_W),
                .VDD_MV          (VDD_MV),
                .SENSE_MARGIN_MV (SENSE_MARGIN_MV)
            ) u_slice (
                .clk          (clk),
                .rst_n        (rst_n),
                .data_in_i    (bus.data_in[gi]),
                .row_wr_i     (bus.row_wr),
                .row_rd_i     (bus.row_rd),
                .bl_wr_o      (bus.bl_wr[gi]),
                .blb_wr_o     (bus.blb_wr[gi]),
                .bl_rd_mv_o   (bus.bl_rd_mv[gi*MV_W +: MV_W]),
                .blb_rd_mv_o  (bus.blb_rd_mv[gi*MV_W +: MV_W]),
                .preout_mv_o  (bus.preout_mv[gi*MV_W +: MV_W]),
                .data_state_o (col_state),
                .dout_o       (bus.dout[gi])
            );

            assign bus.data_state[gi*2 +: 2] = col_state;
        end
    endgenerate

endmodule

// File: tb/tb_sram_bit_column_path.sv
// Directed bench for sram_bit_column_path with two columns driven with complementary data.
module tb_sram_bit_column_path;

    localparam int COLS = 2;
    localparam int MV_W = 12;
    localparam int ST_TRUE  = 0;
    localparam int ST_FALSE = 1;
    localparam int ST_INDET = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sram_bit_column_path_if #(.COLS(COLS), .MV_W(MV_W)) bus ();

    sram_bit_column_path #(
        .COLS            (COLS),
        .MV_W            (MV_W),
        .VDD_MV          (1500),
        .SENSE_MARGIN_MV (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bl(input string tag, input int c, input int bl, input int blb);
        chk({tag, "_bl"},  int'(bus.bl_rd_mv[c*MV_W +: MV_W]),  bl);
        chk({tag, "_blb"}, int'(bus.blb_rd_mv[c*MV_W +: MV_W]), blb);
        $display("%s col%0d bl_rd=%0d blb_rd=%0d", tag, c,
                 bus.bl_rd_mv[c*MV_W +: MV_W], bus.blb_rd_mv[c*MV_W +: MV_W]);
    endtask

    task automatic chk_out(input string tag, input int c, input int pre, input int st, input int d);
        chk({tag, "_pre"},   int'(bus.preout_mv[c*MV_W +: MV_W]), pre);
        chk({tag, "_state"}, int'(bus.data_state[c*2 +: 2]),      st);
        chk({tag, "_dout"},  int'(bus.dout[c]),                   d);
        $display("%s col%0d preout=%0d state=%0d dout=%0d", tag, c,
                 bus.preout_mv[c*MV_W +: MV_W], bus.data_state[c*2 +: 2], bus.dout[c]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.data_in = '0;
        bus.row_wr  = 1'b0;
        bus.row_rd  = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        for (int c = 0; c < COLS; c++) begin
            chk_bl("rst", c, 1500, 1500);
            chk_out("rst", c, 750, ST_INDET, 0);
        end

        // Write col0=1, col1=0 then read
        bus.data_in = 2'b01;
        bus.row_wr  = 1'b1;
        tick();
        bus.row_wr = 1'b0;
        bus.row_rd = 1'b1;
        tick();
        bus.row_rd = 1'b0;
        chk_bl("wr1_rd", 0, 1500, 0);
        chk_bl("wr1_rd", 1, 0, 1500);
        chk_out("wr1_lat", 0, 750, ST_INDET, 0);
        tick();
        chk_out("wr1_sa", 0, 1500, ST_TRUE, 1);
        chk_out("wr1_sa", 1, 0, ST_FALSE, 0);
`ifdef SRAM_RD_PRECHARGE_EN
        chk_bl("idle_pc", 0, 1500, 1500);
`else
        chk_bl("idle_hold", 0, 1500, 0);
`endif
        tick();
        chk_out("idle_keep", 0, 1500, ST_TRUE, 1);

        // Write col0=0, col1=1 then read
        bus.data_in = 2'b10;
        bus.row_wr  = 1'b1;
        tick();
        bus.row_wr = 1'b0;
        bus.row_rd = 1'b1;
        tick();
        bus.row_rd = 1'b0;
        chk_bl("wr0_rd", 0, 0, 1500);
        chk_bl("wr0_rd", 1, 1500, 0);
        tick();
        chk_out("wr0_sa", 0, 0, ST_FALSE, 0);
        chk_out("wr0_sa", 1, 1500, ST_TRUE, 1);

        // Cell hold with row_wr=0; driver follows data_in combinationally
        bus.data_in = 2'b01;
        #1;
        chk("drv_bl_wr",  int'(bus.bl_wr),  1);
        chk("drv_blb_wr", int'(bus.blb_wr), 2);
        $display("drv bl_wr=%b blb_wr=%b", bus.bl_wr, bus.blb_wr);
        tick();
        bus.row_rd = 1'b1;
        tick();
        bus.row_rd = 1'b0;
        tick();
        chk_out("hold", 0, 0, ST_FALSE, 0);
        chk_out("hold", 1, 1500, ST_TRUE, 1);

        // Simultaneous write+read: read returns pre-write value
        bus.data_in = 2'b01;
        bus.row_wr  = 1'b1;
        bus.row_rd  = 1'b1;
        tick();
        bus.row_wr = 1'b0;
        bus.row_rd = 1'b0;
        chk_bl("rbw_rd", 0, 0, 1500);
        tick();
        chk_out("rbw_sa", 0, 0, ST_FALSE, 0);
        chk_out("rbw_sa", 1, 1500, ST_TRUE, 1);
        bus.row_rd = 1'b1;
        tick();
        bus.row_rd = 1'b0;
        chk_bl("rbw_next", 0, 1500, 0);
        tick();
        chk_out("rbw_next", 0, 1500, ST_TRUE, 1);
        chk_out("rbw_next", 1, 0, ST_FALSE, 0);

        // Async reset between edges during a read
        bus.row_rd = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_bl("arst", 0, 1500, 1500);
        chk_out("arst", 0, 750, ST_INDET, 0);
        chk_out("arst", 1, 750, ST_INDET, 0);
        bus.row_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Cell was cleared by reset
        bus.row_rd = 1'b1;
        tick();
        bus.row_rd = 1'b0;
        chk_bl("post_rst", 0, 0, 1500);
        chk_bl("post_rst", 1, 0, 1500);
        tick();
        chk_out("post_rst", 0, 0, ST_FALSE, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
